// File: rtl/spdif_subframe_controller_if.sv
// Decoder-to-sink bundle of spdif_subframe_controller. Build option SPDIF_CHSTAT_EN adds
// the channel-status outputs cs_word and cs_valid.
interface spdif_subframe_controller_if;
   logic        bit_in;
   logic        bit_valid;
   logic        channel_in;
   logic [7:0]  frame_in;
   logic        dec_rst;
   logic [23:0] sample_l;
   logic [23:0] sample_r;
   logic        sample_valid;
   logic        sample_ready;
   logic        locked;
   logic [7:0]  parity_err_cnt;
   logic [7:0]  overrun_cnt;
`ifdef SPDIF_CHSTAT_EN
   logic [31:0] cs_word;
   logic        cs_valid;
`endif

   // master: the environment (decoder + sink); slave: the controller
   modport master (
      output bit_in, bit_valid, channel_in, frame_in, sample_ready,
      input  dec_rst, sample_l, sample_r, sample_valid, locked,
             parity_err_cnt, overrun_cnt
`ifdef SPDIF_CHSTAT_EN
      , input cs_word, cs_valid
`endif
   );

   modport slave (
      input  bit_in, bit_valid, channel_in, frame_in, sample_ready,
      output dec_rst, sample_l, sample_r, sample_valid, locked,
             parity_err_cnt, overrun_cnt
`ifdef SPDIF_CHSTAT_EN
      , output cs_word, cs_valid
`endif
   );
endinterface

// File: rtl/spdif_subframe_controller.sv
// S/PDIF subframe assembler, parity checker, stereo pairer, lock FSM and bit-gap watchdog.
// Build option SPDIF_CHSTAT_EN adds 32-bit channel-status capture (cs_word/cs_valid).
module spdif_subframe_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned LOCK_PAIRS     = 4,
   parameter int unsigned ERR_LIMIT      = 3
) (
   input logic                     clk,
   input logic                     rst,
   spdif_subframe_controller_if.slave bus
);
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned PC_W = $clog2(LOCK_PAIRS + 1);
   localparam int unsigned EC_W = $clog2(ERR_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PC_W-1:0] PAIR_LOCK = PC_W'(LOCK_PAIRS);
   localparam logic [EC_W-1:0] ERR_MAX   = EC_W'(ERR_LIMIT);

   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [27:0]     sf_q, sf_d;
   logic            chan_q, chan_d;
   logic            done_q, done_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_arm_q, wd_arm_d;
   logic            left_pend_q, left_pend_d;
   logic [23:0]     hold_l_q, hold_l_d;
   logic [PC_W-1:0] pair_cnt_q, pair_cnt_d;
   logic [EC_W-1:0] err_cnt_q, err_cnt_d;
   logic            dec_rst_q, dec_rst_d;
   logic [23:0]     sample_l_q, sample_l_d;
   logic [23:0]     sample_r_q, sample_r_d;
   logic            sample_valid_q, sample_valid_d;
   logic [7:0]      perr_q, perr_d;
   logic [7:0]      ovr_q, ovr_d;
`ifdef SPDIF_CHSTAT_EN
   logic [7:0]      frame_q, frame_d;
   logic [31:0]     cs_acc_q, cs_acc_d;
   logic [31:0]     cs_word_q, cs_word_d;
   logic            cs_valid_q, cs_valid_d;
   logic            cs_clean_q, cs_clean_d;
`endif

   logic timeout, frame_err, sub_ok, bad;

   assign timeout   = !bus.bit_valid && wd_arm_q && (wd_q == WD_LAST);
   assign frame_err = bus.bit_valid && (bit_cnt_q != '0) && (bus.channel_in != chan_q);
   assign sub_ok    = done_q && !(^sf_q);
   assign bad       = (done_q && (^sf_q)) || frame_err;

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      sf_d           = sf_q;
      chan_d         = chan_q;
      done_d         = 1'b0;
      wd_d           = wd_q;
      wd_arm_d       = wd_arm_q;
      left_pend_d    = left_pend_q;
      hold_l_d       = hold_l_q;
      pair_cnt_d     = pair_cnt_q;
      err_cnt_d      = err_cnt_q;
      dec_rst_d      = 1'b0;
      sample_l_d     = sample_l_q;
      sample_r_d     = sample_r_q;
      sample_valid_d = sample_valid_q;
      perr_d         = perr_q;
      ovr_d          = ovr_q;
`ifdef SPDIF_CHSTAT_EN
      frame_d        = frame_q;
      cs_acc_d       = cs_acc_q;
      cs_word_d      = cs_word_q;
      cs_valid_d     = 1'b0;
      cs_clean_d     = cs_clean_q;
`endif

      // Watchdog stays disarmed until the first strobe, so an idle link pulses dec_rst only once
      if (bus.bit_valid) begin
         wd_d     = '0;
         wd_arm_d = 1'b1;
      end else if (wd_arm_q) begin
         wd_d = wd_q + 1'b1;
      end

      if (bus.bit_valid) begin
         if (bit_cnt_q == '0 || frame_err) begin
            sf_d[0]   = bus.bit_in;
            chan_d    = bus.channel_in;
`ifdef SPDIF_CHSTAT_EN
            frame_d   = bus.frame_in;
`endif
            bit_cnt_d = 5'd1;
         end else begin
            sf_d[bit_cnt_q] = bus.bit_in;
            if (bit_cnt_q == 5'd27) begin
               bit_cnt_d = '0;
               done_d    = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         if (state_q == UNLOCKED) state_d = ACQUIRE;
      end

      if (sample_valid_q && bus.sample_ready) sample_valid_d = 1'b0;

      if (timeout) begin
         dec_rst_d      = 1'b1;
         bit_cnt_d      = '0;
         done_d         = 1'b0;
         left_pend_d    = 1'b0;
         pair_cnt_d     = '0;
         err_cnt_d      = '0;
         sample_valid_d = 1'b0;
         state_d        = UNLOCKED;
         wd_d           = '0;
         wd_arm_d       = 1'b0;
`ifdef SPDIF_CHSTAT_EN
         cs_clean_d     = 1'b0;
`endif
      end else if (bad) begin
         if (perr_q != 8'hFF) perr_d = perr_q + 1'b1;
         if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
         left_pend_d = 1'b0;
         pair_cnt_d  = '0;
         if (state_q == LOCKED && err_cnt_d == ERR_MAX) state_d = ACQUIRE;
`ifdef SPDIF_CHSTAT_EN
         cs_clean_d  = 1'b0;
`endif
      end else if (sub_ok) begin
         if (!chan_q) begin
            hold_l_d    = sf_q[23:0];
            left_pend_d = 1'b1;
            err_cnt_d   = '0;
`ifdef SPDIF_CHSTAT_EN
            if (frame_q < 8'd32) cs_acc_d[frame_q[4:0]] = sf_q[26];
            if (frame_q == 8'd0) cs_clean_d = 1'b1;
            if (frame_q == 8'd191) begin
               cs_clean_d = 1'b0;
               if (cs_clean_q) begin
                  cs_word_d  = cs_acc_q;
                  cs_valid_d = 1'b1;
               end
            end
`endif
         end else if (left_pend_q) begin
            left_pend_d = 1'b0;
            if (pair_cnt_q != PAIR_LOCK) pair_cnt_d = pair_cnt_q + 1'b1;
            if (state_q == ACQUIRE && pair_cnt_d == PAIR_LOCK) state_d = LOCKED;
            if (state_q == LOCKED) begin
               if (!sample_valid_q || bus.sample_ready) begin
                  sample_l_d     = hold_l_q;
                  sample_r_d     = sf_q[23:0];
                  sample_valid_d = 1'b1;
               end else if (ovr_q != 8'hFF) begin
                  ovr_d = ovr_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= UNLOCKED;
         bit_cnt_q      <= '0;
         sf_q           <= '0;
         chan_q         <= 1'b0;
         done_q         <= 1'b0;
         wd_q           <= '0;
         wd_arm_q       <= 1'b0;
         left_pend_q    <= 1'b0;
         hold_l_q       <= '0;
         pair_cnt_q     <= '0;
         err_cnt_q      <= '0;
         dec_rst_q      <= 1'b0;
         sample_l_q     <= '0;
         sample_r_q     <= '0;
         sample_valid_q <= 1'b0;
         perr_q         <= '0;
         ovr_q          <= '0;
`ifdef SPDIF_CHSTAT_EN
         frame_q        <= '0;
         cs_acc_q       <= '0;
         cs_word_q      <= '0;
         cs_valid_q     <= 1'b0;
         cs_clean_q     <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         sf_q           <= sf_d;
         chan_q         <= chan_d;
         done_q         <= done_d;
         wd_q           <= wd_d;
         wd_arm_q       <= wd_arm_d;
         left_pend_q    <= left_pend_d;
         hold_l_q       <= hold_l_d;
         pair_cnt_q     <= pair_cnt_d;
         err_cnt_q      <= err_cnt_d;
         dec_rst_q      <= dec_rst_d;
         sample_l_q     <= sample_l_d;
         sample_r_q     <= sample_r_d;
         sample_valid_q <= sample_valid_d;
         perr_q         <= perr_d;
         ovr_q          <= ovr_d;
`ifdef SPDIF_CHSTAT_EN
         frame_q        <= frame_d;
         cs_acc_q       <= cs_acc_d;
         cs_word_q      <= cs_word_d;
         cs_valid_q     <= cs_valid_d;
         cs_clean_q     <= cs_clean_d;
`endif
      end
   end

   assign bus.dec_rst        = dec_rst_q;
   assign bus.sample_l       = sample_l_q;
   assign bus.sample_r       = sample_r_q;
   assign bus.sample_valid   = sample_valid_q;
   assign bus.locked         = (state_q == LOCKED);
   assign bus.parity_err_cnt = perr_q;
   assign bus.overrun_cnt    = ovr_q;
`ifdef SPDIF_CHSTAT_EN
   assign bus.cs_word        = cs_word_q;
   assign bus.cs_valid       = cs_valid_q;
`endif
endmodule

// File: tb/tb_spdif_subframe_controller.sv
// Directed bench for spdif_subframe_controller: lock, parity errors, backpressure,
// watchdog timeout, framing errors, mid-subframe reset and (SPDIF_CHSTAT_EN) channel status.
module tb_spdif_subframe_controller;
   logic        clk = 1'b0;
   logic        rst;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   int unsigned last_strobe = 0;

   spdif_subframe_controller_if bus ();

   spdif_subframe_controller #(
      .TIMEOUT_CYCLES(4096),
      .LOCK_PAIRS(4),
      .ERR_LIMIT(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 28-bit subframe: sample, V=0, U=0, C, P chosen for even parity (inverted when flip_p)
   function automatic logic [27:0] mk_word(input logic [23:0] s, input logic c, input logic flip_p);
      logic [26:0] lo;
      lo = {c, 1'b0, 1'b0, s};
      return {(^lo) ^ flip_p, lo};
   endfunction

   task automatic send_bit(input logic b, input logic ch, input logic [7:0] fr);
      bus.bit_in     = b;
      bus.channel_in = ch;
      bus.frame_in   = fr;
      bus.bit_valid  = 1'b1;
      @(negedge clk);
      last_strobe   = cyc;
      bus.bit_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_sub(input logic [27:0] w, input logic ch, input logic [7:0] fr);
      for (int i = 0; i < 28; i++) send_bit(w[i], ch, fr);
   endtask

   task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
      send_sub(mk_word(l, 1'b0, 1'b0), 1'b0, 8'd0);
      send_sub(mk_word(r, 1'b0, 1'b0), 1'b1, 8'd0);
   endtask

   initial begin
      int n;
      logic [27:0] w;
      rst              = 1'b1;
      bus.bit_in       = 1'b0;
      bus.bit_valid    = 1'b0;
      bus.channel_in   = 1'b0;
      bus.frame_in     = 8'd0;
      bus.sample_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dec_rst", bus.dec_rst, 0);
      chk("rst_valid", bus.sample_valid, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_sample_l", bus.sample_l, 0);
      chk("rst_sample_r", bus.sample_r, 0);
      chk("rst_perr", bus.parity_err_cnt, 0);
      chk("rst_ovr", bus.overrun_cnt, 0);

      // Lock after four good pairs; the fifth is delivered
      for (int k = 0; k < 3; k++) send_pair(24'h123456, 24'hABCDEF);
      chk("lock_after3", bus.locked, 0);
      send_pair(24'h123456, 24'hABCDEF);
      chk("lock_after4", bus.locked, 1);
      chk("lock_no_out", bus.sample_valid, 0);
      send_pair(24'h123456, 24'hABCDEF);
      chk("pair5_valid", bus.sample_valid, 1);
      chk("pair5_l", bus.sample_l, 32'h123456);
      chk("pair5_r", bus.sample_r, 32'hABCDEF);
      @(negedge clk);
      chk("pair5_valid_drop", bus.sample_valid, 0);

      // Three bad-parity lefts drop the lock
      for (int k = 0; k < 3; k++) begin
         send_sub(mk_word(24'h123456, 1'b0, 1'b1), 1'b0, 8'd0);
         if (k == 1) chk("perr2_locked", bus.locked, 1);
      end
      chk("perr3_cnt", bus.parity_err_cnt, 3);
      chk("perr3_locked", bus.locked, 0);
      chk("perr3_valid", bus.sample_valid, 0);
      for (int k = 0; k < 3; k++) send_pair(24'h123456, 24'hABCDEF);
      chk("relock_after3", bus.locked, 0);
      chk("relock_no_out", bus.sample_valid, 0);
      send_pair(24'h123456, 24'hABCDEF);
      chk("relock_after4", bus.locked, 1);

      // Backpressure: first pair held, the next two dropped
      bus.sample_ready = 1'b0;
      send_pair(24'h000111, 24'h000222);
      chk("bp_valid1", bus.sample_valid, 1);
      send_pair(24'h333333, 24'h444444);
      send_pair(24'h555555, 24'h666666);
      chk("bp_hold_l", bus.sample_l, 32'h000111);
      chk("bp_hold_r", bus.sample_r, 32'h000222);
      chk("bp_valid3", bus.sample_valid, 1);
      chk("bp_ovr", bus.overrun_cnt, 2);
      bus.sample_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", bus.sample_valid, 0);

      // Timeout with a pair pending on the output
      bus.sample_ready = 1'b0;
      send_pair(24'h0A0B0C, 24'h0D0E0F);
      chk("to_valid_before", bus.sample_valid, 1);
      n = 0;
      while (!bus.dec_rst && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("to_dec_rst", bus.dec_rst, 1);
      chk("to_gap", cyc - last_strobe, 4096);
      chk("to_locked", bus.locked, 0);
      chk("to_valid", bus.sample_valid, 0);
      @(negedge clk);
      chk("to_dec_rst_width", bus.dec_rst, 0);
      chk("to_perr_kept", bus.parity_err_cnt, 3);
      chk("to_ovr_kept", bus.overrun_cnt, 2);
      bus.sample_ready = 1'b1;

      // Framing: channel toggles after 10 left bits; the right subframe is not paired
      w = mk_word(24'h0F0F0F, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) send_bit(w[i], 1'b0, 8'd0);
      send_sub(mk_word(24'h00FFFF, 1'b0, 1'b0), 1'b1, 8'd0);
      chk("fr_perr", bus.parity_err_cnt, 4);
      chk("fr_valid", bus.sample_valid, 0);
      for (int k = 0; k < 3; k++) send_pair(24'h123456, 24'hABCDEF);
      chk("fr_locked_after3", bus.locked, 0);
      send_pair(24'h123456, 24'hABCDEF);
      chk("fr_locked_after4", bus.locked, 1);
      chk("fr_perr_final", bus.parity_err_cnt, 4);

      // Reset in the middle of a subframe
      w = mk_word(24'h555555, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(w[i], 1'b0, 8'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_dec_rst_during", bus.dec_rst, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_dec_rst", bus.dec_rst, 0);
      chk("mrst_locked", bus.locked, 0);
      chk("mrst_perr", bus.parity_err_cnt, 0);
      chk("mrst_ovr", bus.overrun_cnt, 0);
      send_sub(mk_word(24'h123456, 1'b0, 1'b0), 1'b0, 8'd0);
      chk("mrst_clean_subframe", bus.parity_err_cnt, 0);

`ifdef SPDIF_CHSTAT_EN
      chk("cs_rst_valid", bus.cs_valid, 0);
      chk("cs_rst_word", bus.cs_word, 0);
      for (int f = 0; f < 192; f++) begin
         send_sub(mk_word(24'h000100 + 24'(f), (f == 0 || f == 2 || f == 31), 1'b0),
                  1'b0, 8'(f));
         if (f == 190) chk("cs_valid_early", bus.cs_valid, 0);
      end
      chk("cs_valid", bus.cs_valid, 1);
      chk("cs_word", bus.cs_word, 32'h80000005);
      @(negedge clk);
      chk("cs_valid_width", bus.cs_valid, 0);
      chk("cs_word_hold", bus.cs_word, 32'h80000005);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/spdif_subframe_controller.md
Name: spdif_subframe_controller

Overview:
- Sits directly downstream of the biphase-mark decoder; consumes its serial decoded bits, channel flag and frame index.
- Assembles 28-bit subframes, checks even parity, pairs left/right into 24-bit stereo samples and hands them to the audio sink over a valid/ready handshake.
- Owns link lock state and a bit-gap watchdog. On loss of activity it issues a one-cycle resynchronising reset to the decoder.

Parameters:
- TIMEOUT_CYCLES, 4096: clk cycles without bit_valid before the link is declared dead.
- LOCK_PAIRS, 4: consecutive good stereo pairs required to enter LOCKED.
- ERR_LIMIT, 3: consecutive bad subframes that force LOCKED back to ACQUIRE.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- bit_in, input, 1: decoded data bit from decoder.
- bit_valid, input, 1: one-cycle strobe, bit_in valid.
- channel_in, input, 1: decoder channel flag, 0 = left, 1 = right.
- frame_in, input, 8: decoder frame index within 192-frame block.
- dec_rst, output, 1: one-cycle reset pulse to decoder.
- sample_l, output, 24: left sample.
- sample_r, output, 24: right sample.
- sample_valid, output, 1: stereo pair available.
- sample_ready, input, 1: sink accepts pair.
- locked, output, 1: high in LOCKED state.
- parity_err_cnt, output, 8: saturating parity/framing error count.
- overrun_cnt, output, 8: saturating dropped-pair count.

Behaviour:
- Reset: all outputs 0; state UNLOCKED; bit counter, watchdog, pair and error counters 0; left-pending flag clear.
- Subframe assembly:
  - Each bit_valid shifts bit_in into index bit_cnt (LSB first); bit_cnt increments 0..27.
  - channel_in and frame_in are sampled on the bit_cnt==0 strobe.
  - Completion is evaluated in the cycle after the 28th strobe; bit_cnt returns to 0.
- Field map, by bit index: 0..23 sample (bit i maps to sample[i]), 24 V, 25 U, 26 C, 27 P.
- Good subframe: XOR of all 28 bits == 0.
- Framing error: channel_in differs from the captured channel while bit_cnt != 0.
  - Partial subframe is discarded; bit_cnt restarts at 0 with the current strobe as bit 0.
  - Counted as an error.
- Bad subframe (parity or framing):
  - parity_err_cnt +1, saturating at 255.
  - Left-pending flag cleared; consecutive-good-pair count cleared; consecutive-error count +1.
- Good left subframe: captured into the left holding register; left-pending set; consecutive-error count cleared.
- Good right subframe:
  - With left-pending set, this forms a pair and left-pending clears. Without it, the subframe is discarded without error.
  - Pair output depends on state:
    - LOCKED, output register free (sample_valid low, or sample_ready high this cycle): sample_l/sample_r load and sample_valid rises the next cycle.
    - LOCKED, output register occupied: the pair is dropped and overrun_cnt +1 (saturating).
    - Not LOCKED: the pair is never output.
- Handshake: sample_valid holds with stable data until sample_valid && sample_ready; it falls the following cycle unless a new pair loads in the same cycle.
- State machine:
  - UNLOCKED → ACQUIRE on first bit_valid.
  - ACQUIRE → LOCKED after LOCK_PAIRS consecutive good pairs.
  - LOCKED → ACQUIRE when the consecutive-error count reaches ERR_LIMIT; sample_valid is unaffected.
  - Any state → UNLOCKED on watchdog expiry.
- locked = (state == LOCKED).
- Watchdog:
  - Cleared on every bit_valid; increments otherwise.
  - On reaching TIMEOUT_CYCLES: dec_rst pulses high for exactly 1 cycle; bit_cnt, left-pending and pair/error run counts clear; sample_valid clears; state goes to UNLOCKED. The watchdog then holds at 0 until the next bit_valid.
  - parity_err_cnt and overrun_cnt survive a timeout and clear only on rst.
- Simultaneous events:
  - A completing subframe plus a watchdog expiry in the same cycle: the timeout wins.
  - A load plus a sample_ready in the same cycle: the load wins.
- rst mid-subframe: partial data is discarded and dec_rst is not pulsed.

Optional Feature:
- Macro: SPDIF_CHSTAT_EN.
- When defined, adds two outputs: cs_word (32) and cs_valid (1).
  - The C bit of each good left subframe with frame_in < 32 is written to cs_word[frame_in].
  - When the good left subframe has frame_in == 191 and no bad subframe has occurred since frame_in == 0, cs_valid pulses for 1 cycle and cs_word holds until the next pulse.
  - cs_word and cs_valid reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Lock: 4 good L/R pairs (L=0x123456, R=0xABCDEF, correct parity), sample_ready=1 → locked rises after the 4th pair; the 5th pair outputs sample_l=0x123456, sample_r=0xABCDEF with a 1-cycle valid.
- Parity error: while locked, 3 consecutive left subframes with P flipped → parity_err_cnt=3, locked falls, no sample_valid; 4 further good pairs → relock.
- Backpressure: locked, sample_ready=0, 3 good pairs → first pair held stable, overrun_cnt=2; raise sample_ready → valid drops the next cycle.
- Timeout: stop bit_valid for 4096 cycles → dec_rst high exactly 1 cycle, locked=0, sample_valid=0; error counters unchanged.
- Framing: channel_in toggles after 10 bits of a left subframe → parity_err_cnt +1; the following right subframe (28 bits) is counted but not paired.
- SPDIF_CHSTAT_EN: a 192-frame block with C=1 on left frames 0, 2 and 31 → cs_valid pulses after frame 191 with cs_word=0x80000005.
